// File: rtl/imem_load_ctrl_pkg.sv
// rtl/imem_load_ctrl_pkg.sv - shared state encoding and constants for the instruction ROM loader
package imem_load_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_ARM  = 2'd1,
        ST_RECV = 2'd2,
        ST_DONE = 2'd3
    } load_state_t;

    localparam int          DEFAULT_TIMEOUT_CYCLES = 1_000_000;
    localparam logic [31:0] ZeroWord               = 32'h0000_0000;

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - little-endian byte-to-word assembly with zero-pad flush and one-cycle write pulse
module imem_word_packer
    import imem_load_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    input  logic        flush,
    output logic        wen,
    output logic [31:0] wdata,
    output logic [1:0]  byte_cnt
);

    // Only lanes 0..2 are buffered; the fourth byte goes straight into wdata.
    logic [23:0] lanes;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lanes    <= '0;
            byte_cnt <= 2'd0;
            wen      <= 1'b0;
            wdata    <= ZeroWord;
        end else begin
            wen <= 1'b0;
            if (clear) begin
                lanes    <= '0;
                byte_cnt <= 2'd0;
            end else if (accept) begin
                if (byte_cnt == 2'd3) begin
                    wen      <= 1'b1;
                    wdata    <= {data, lanes};
                    lanes    <= '0;
                    byte_cnt <= 2'd0;
                end else begin
                    case (byte_cnt)
                        2'd0:    lanes[7:0]   <= data;
                        2'd1:    lanes[15:8]  <= data;
                        default: lanes[23:16] <= data;
                    endcase
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end else if (flush && (byte_cnt != 2'd0)) begin
                // Unfilled upper lanes are already zero because lanes is cleared after every write.
                wen      <= 1'b1;
                wdata    <= {8'h00, lanes};
                lanes    <= '0;
                byte_cnt <= 2'd0;
            end
        end
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - instruction ROM port owner: CPU fetch pass-through or UART word loader (IMEM_LOAD_CHECKSUM_EN adds checksum)
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 14,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_req,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_wen,
    output logic [31:0]       rom_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       checksum
);

    localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    load_state_t       state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr;
    logic [IDLE_W-1:0] idle_cnt;
    logic [1:0]        byte_cnt;
    logic              start, timeout, accept, flush, full_write;

    assign start      = (state_q == ST_RUN) && load_req;
    assign timeout    = (state_q == ST_RECV) && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES));
    // Bytes are refused once the timeout hits so the flush cycle cannot be disturbed.
    assign accept     = rx_valid && load_req &&
                        ((state_q == ST_ARM) || ((state_q == ST_RECV) && !timeout));
    assign flush      = timeout && load_req;
    assign full_write = rom_wen && (wr_ptr == LAST_ADDR);

    assign cpu_hold  = (state_q != ST_RUN);
    assign load_done = (state_q == ST_DONE);
    assign rom_addr  = cpu_hold ? wr_ptr : cpu_addr;

    imem_word_packer u_packer (
        .clock    (clock),
        .reset    (reset),
        .clear    (start),
        .accept   (accept),
        .data     (rx_data),
        .flush    (flush),
        .wen      (rom_wen),
        .wdata    (rom_wdata),
        .byte_cnt (byte_cnt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (load_req) state_d = ST_ARM;
            ST_ARM: begin
                if (!load_req)     state_d = ST_RUN;
                else if (rx_valid) state_d = ST_RECV;
            end
            ST_RECV: begin
                // A partial-word flush stays in RECV for its write cycle; byte_cnt is 0 afterwards.
                if (!load_req || full_write || (timeout && (byte_cnt == 2'd0)))
                    state_d = ST_DONE;
            end
            ST_DONE: if (!load_req) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            word_count <= '0;
            idle_cnt   <= '0;
        end else if (start) begin
            wr_ptr     <= '0;
            word_count <= '0;
            idle_cnt   <= '0;
        end else begin
            if (rom_wen) begin
                wr_ptr     <= wr_ptr + ADDR_W'(1);
                word_count <= word_count + (ADDR_W + 1)'(1);
            end
            if (state_q == ST_ARM) begin
                idle_cnt <= '0;
            end else if ((state_q == ST_RECV) && !timeout) begin
                idle_cnt <= rx_valid ? '0 : idle_cnt + IDLE_W'(1);
            end
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)       checksum <= ZeroWord;
        else if (start)   checksum <= ZeroWord;
        else if (rom_wen) checksum <= checksum + rom_wdata;
    end
`else
    assign checksum = ZeroWord;
`endif

endmodule
